// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM wrapper between NUM_REQ masters.
// Grants are combinational; responses (rdata/ack/err) are returned one cycle after the grant.

module sp_ram_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 8192
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ-1:0]                    we_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  be_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]                    gnt_o,
    output logic [NUM_REQ-1:0]                    rvalid_o,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic                                  err_o,
    output logic                                  ram_en_o,
    output logic [ADDR_WIDTH-1:0]                 ram_addr_o,
    output logic                                  ram_we_o,
    output logic [DATA_WIDTH/8-1:0]               ram_be_o,
    output logic [DATA_WIDTH-1:0]                 ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]                 ram_rdata_i,
    input  logic                                  test_bypass_i,
    output logic                                  ram_bypass_o
);

    localparam int          PTR_W      = $clog2(NUM_REQ);
    localparam int          BE_W       = DATA_WIDTH / 8;
    localparam logic [31:0] ADDR_LIMIT = 32'(NUM_WORDS * BE_W);

    // Index base+off modulo NUM_REQ; off never exceeds NUM_REQ, so one subtraction suffices.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= NUM_REQ) ? PTR_W'(sum - NUM_REQ) : PTR_W'(sum);
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [PTR_W-1:0]      rr_ptr_r;
    logic [PTR_W-1:0]      cand_s;
    logic [PTR_W-1:0]      win_idx_s;
    logic                  win_found_s;
    logic                  grant_s;
    logic                  in_range_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic                  sel_we_s;
    logic [BE_W-1:0]       sel_be_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;

    logic [PTR_W-1:0]      rsp_id_r;
    logic                  rsp_v_r;
    logic                  rsp_rd_r;
    logic                  rsp_err_r;

    // Winner search: scanning offsets from highest to lowest lets the nearest requester overwrite.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s      = wrap_idx(rr_ptr_r, i);
            win_found_s = win_found_s | req_i[cand_s];
            win_idx_s   = req_i[cand_s] ? cand_s : win_idx_s;
        end
    end

    // Reset gates the grant so nothing reaches the RAM while rst_n is low.
    assign grant_s     = win_found_s & rst_n;
    assign sel_addr_s  = addr_i[win_idx_s];
    assign sel_we_s    = we_i[win_idx_s];
    assign sel_be_s    = be_i[win_idx_s];
    assign sel_wdata_s = wdata_i[win_idx_s];
    assign in_range_s  = (32'(sel_addr_s) < ADDR_LIMIT);

    // Grant and RAM-side request mux; out-of-range accesses are granted but never enable the RAM.
    always_comb begin
        gnt_o       = '0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (grant_s) begin
            gnt_o       = to_onehot(win_idx_s);
            ram_en_o    = in_range_s;
            ram_we_o    = sel_we_s & in_range_s;
            ram_be_o    = in_range_s ? sel_be_s : '0;
            ram_addr_o  = sel_addr_s;
            ram_wdata_o = sel_wdata_s;
        end else begin
            gnt_o    = '0;
            ram_en_o = 1'b0;
        end
    end

    // Round-robin pointer and response tracking, loaded every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r  <= '0;
            rsp_id_r  <= '0;
            rsp_v_r   <= 1'b0;
            rsp_rd_r  <= 1'b0;
            rsp_err_r <= 1'b0;
        end else begin
            rsp_id_r  <= win_idx_s;
            rsp_v_r   <= grant_s;
            rsp_rd_r  <= grant_s & in_range_s & ~sel_we_s;
            rsp_err_r <= grant_s & ~in_range_s;
            if (grant_s) begin
                rr_ptr_r <= wrap_idx(win_idx_s, 1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign rvalid_o     = to_onehot(rsp_id_r) & {NUM_REQ{rsp_v_r}};
    assign rdata_o      = rsp_rd_r ? ram_rdata_i : '0;
    assign err_o        = rsp_v_r & rsp_err_r;
    assign ram_bypass_o = test_bypass_i;

    sp_ram_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .gnt    (gnt_o),
        .rvalid (rvalid_o),
        .ram_en (ram_en_o),
        .err    (err_o)
    );

endmodule

// Protocol invariants of the arbiter: one-hot grants/responses and grant-to-response pairing.
module sp_ram_arbiter_chk #(
    parameter int NUM_REQ = 2
) (
    input logic               clk,
    input logic               rst_n,
    input logic [NUM_REQ-1:0] gnt,
    input logic [NUM_REQ-1:0] rvalid,
    input logic               ram_en,
    input logic               err
);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rvalid));
    a_en_needs_gnt: assert property (@(posedge clk) disable iff (!rst_n) ram_en |-> (|gnt));
    a_gnt_then_rsp: assert property (@(posedge clk) disable iff (!rst_n) (|gnt) |=> (|rvalid));
    a_err_qualified: assert property (@(posedge clk) disable iff (!rst_n) err |-> (|rvalid));

endmodule
